// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store memory-stage controller
//   mem_size_e  : access size encoding (11 is treated as WORD by users)
//   lsu_state_e : bus handshake state
//   rot_amt     : data rotate amount for a byte offset
//   byte_en     : byte-enable mask for a size/offset pair
package lsu_pkg;

   typedef enum logic [1:0] {
      BYTE = 2'b00,
      HALF = 2'b01,
      WORD = 2'b10
   } mem_size_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      RESP = 2'b10
   } lsu_state_e;

   // (4 - off) mod 4 is simply the 2-bit two's-complement negation
   function automatic logic [1:0] rot_amt(input logic [1:0] off);
      return 2'd0 - off;
   endfunction

   function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
      return size == BYTE ? 4'b0001 << off :
             size == HALF ? 4'b0011 << off : 4'b1111;
   endfunction

endpackage

// File: rtl/lsu_align_chk.sv
// lsu_align_chk: combinational size/offset decode for one memory op
//   i_size       : access size (00 byte, 01 half, 1x word)
//   i_off        : byte offset, address bits [1:0]
//   o_be         : byte enables on the word bus
//   o_rot        : rotate amount for the datapath
//   o_misaligned : half on odd offset or word on non-zero offset
module lsu_align_chk
   import lsu_pkg::*;
(
   input  logic [1:0] i_size,
   input  logic [1:0] i_off,
   output logic [3:0] o_be,
   output logic [1:0] o_rot,
   output logic       o_misaligned
);

   assign o_be  = byte_en(i_size, i_off);
   assign o_rot = rot_amt(i_off);
   // any size other than byte/half is handled as a word
   assign o_misaligned = i_size == HALF ? i_off[0] : i_size != BYTE && i_off != 2'b00;

endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store memory-stage controller driving a req/gnt/rvalid data bus
//   clk, rst                : clock, synchronous active-high reset
//   ex_*                    : EX-stage memory op (valid, store, size, unsigned, addr)
//   ex_rotate_amount, stall : combinational store rotate and pipeline freeze
//   dmem_*                  : data-memory bus (req/we/addr/be out, gnt/rvalid in)
//   mem_*                   : registered load rotate and size/sign flags of the accepted op
//   load_valid              : pulse one cycle after the accepted rvalid
//   misaligned, bus_err     : one-cycle fault pulses, faulting address in fault_addr
module lsu_mem_ctrl
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic        ex_store,
   input  logic [1:0]  ex_size,
   input  logic        ex_unsigned,
   input  logic [31:0] ex_addr,
   output logic [1:0]  ex_rotate_amount,
   output logic        stall,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   input  logic        dmem_gnt,
   input  logic        dmem_rvalid,
   output logic [1:0]  mem_rotate_amount,
   output logic        mem_byte_op,
   output logic        mem_half_op,
   output logic        mem_unsigned_op,
   output logic        load_valid,
   output logic        misaligned,
   output logic        bus_err,
   output logic [31:0] fault_addr
);

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);

   lsu_state_e       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_addr;
   logic [31:0]      r_fault_addr;
   logic [3:0]       r_be;
   logic [1:0]       r_rot;
   logic             r_we;
   logic             r_byte;
   logic             r_half;
   logic             r_uns;
   logic             r_load_valid;
   logic             r_misaligned;
   logic             r_bus_err;

   logic [3:0] w_be;
   logic [1:0] w_rot;
   logic       w_mis;
   logic       w_accept;
   logic       w_mis_fault;
   logic       w_waiting;
   logic       w_timeout;
   logic       w_done;

   lsu_align_chk u_align (
      .i_size       (ex_size),
      .i_off        (ex_addr[1:0]),
      .o_be         (w_be),
      .o_rot        (w_rot),
      .o_misaligned (w_mis)
   );

   assign stall = (r_state == REQ && !(dmem_gnt && r_we)) || (r_state == RESP && !dmem_rvalid);

   assign w_accept    = ex_valid && !stall && !w_mis;
   assign w_mis_fault = ex_valid && !stall && w_mis;
   // a load grant counts as progress, so only a cycle with no bus event can time out
   assign w_waiting   = (r_state == REQ && !dmem_gnt) || (r_state == RESP && !dmem_rvalid);
   assign w_timeout   = TIMEOUT_CYCLES != 0 && w_waiting && r_cnt >= TO_LAST;
   assign w_done      = (r_state == REQ && dmem_gnt && r_we) || (r_state == RESP && dmem_rvalid);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_addr       <= '0;
         r_fault_addr <= '0;
         r_be         <= '0;
         r_rot        <= '0;
         r_we         <= 1'b0;
         r_byte       <= 1'b0;
         r_half       <= 1'b0;
         r_uns        <= 1'b0;
         r_load_valid <= 1'b0;
         r_misaligned <= 1'b0;
         r_bus_err    <= 1'b0;
      end else begin
         r_load_valid <= r_state == RESP && dmem_rvalid;
         r_misaligned <= w_mis_fault;
         r_bus_err    <= w_timeout;
         // misaligned needs !stall while a timeout needs stall, so these never collide
         if (w_mis_fault)
            r_fault_addr <= ex_addr;
         else if (w_timeout)
            r_fault_addr <= r_addr;
         r_cnt <= w_accept ? '0 : r_state != IDLE ? r_cnt + CNT_W'(1) : r_cnt;
         if (w_accept) begin
            r_state <= REQ;
            r_addr  <= ex_addr;
            r_be    <= w_be;
            r_we    <= ex_store;
            r_rot   <= w_rot;
            r_byte  <= ex_size == BYTE;
            r_half  <= ex_size == HALF;
            r_uns   <= ex_unsigned;
         end else if (w_done || w_timeout)
            r_state <= IDLE;
         else if (r_state == REQ && dmem_gnt)
            r_state <= RESP;
      end
   end

   assign ex_rotate_amount  = w_rot;
   assign dmem_req          = r_state == REQ;
   assign dmem_we           = r_we;
   assign dmem_addr         = {r_addr[31:2], 2'b00};
   assign dmem_be           = r_be;
   assign mem_rotate_amount = r_rot;
   assign mem_byte_op       = r_byte;
   assign mem_half_op       = r_half;
   assign mem_unsigned_op   = r_uns;
   assign load_valid        = r_load_valid;
   assign misaligned        = r_misaligned;
   assign bus_err           = r_bus_err;
   assign fault_addr        = r_fault_addr;

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store memory-stage controller that sits alongside and upstream of the load/store datapath.
- Takes an EX-stage memory op: effective address, size, signedness, load/store.
- Generates the rotate amounts and size flags the datapath needs. Drives the data-memory bus with a request/grant/response handshake. Stalls the pipeline while an access is outstanding.
- Detects misaligned accesses and bus timeouts, and produces a load-valid strobe aligned with the datapath's registered load result.

Parameters:
- TIMEOUT_CYCLES, 64, cycles in REQ+RESP before bus error; 0 disables timeout.
- CNT_W, 8, width of the timeout counter; must satisfy TIMEOUT_CYCLES < 2**CNT_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  EX holds a memory op.
- ex_store  in  1  1=store, 0=load.
- ex_size  in  2  00 byte, 01 half, 10 word; 11 is illegal and treated as word.
- ex_unsigned  in  1  zero-extend load.
- ex_addr  in  32  effective byte address.
- ex_rotate_amount  out  2  combinational; store rotate for the datapath.
- stall  out  1  combinational; freeze EX and earlier stages.
- dmem_req  out  1  bus request.
- dmem_we  out  1  write enable.
- dmem_addr  out  32  word-aligned address, bits [1:0]=00.
- dmem_be  out  4  byte enables.
- dmem_gnt  in  1  request accepted this cycle.
- dmem_rvalid  in  1  mem_read_data is valid this cycle.
- mem_rotate_amount  out  2  registered; load rotate for the datapath.
- mem_byte_op, mem_half_op, mem_unsigned_op  out  1 each  registered size/sign flags.
- load_valid  out  1  pulse one cycle after dmem_rvalid, coincident with the datapath load_data register.
- misaligned  out  1  one-cycle pulse; carries the faulting op's address in fault_addr.
- bus_err  out  1  one-cycle pulse on timeout.
- fault_addr  out  32  registered address of the last faulting op.

Behaviour:
- Reset: state=IDLE. All outputs are 0 (dmem_req, dmem_we, dmem_be, dmem_addr, mem_* flags, load_valid, misaligned, bus_err, fault_addr). Counter=0.
- Offset: off = ex_addr[1:0].
- Rotate amounts:
  - ex_rotate_amount = (4 - off) mod 4, i.e. 2-bit negate of off: 0→0, 1→3, 2→2, 3→1.
  - mem_rotate_amount is the same function, registered from the accepted op.
- Byte enables:
  - byte = 4'b0001 << off
  - half = 4'b0011 << off
  - word = 4'b1111
- Misaligned: half with off[0]=1, or word with off!=0.
  - Issues no bus request.
  - Pulses misaligned the next cycle and latches fault_addr.
  - Does not stall.
- Accept: op accepted when ex_valid && !stall && aligned. On accept, register the address, be, we, and mem_* flags; the next state is REQ.
- States:
  - IDLE: dmem_req=0. Transitions to REQ on accept.
  - REQ: dmem_req=1, outputs held stable until dmem_gnt.
    - Store granted: complete. Accept the next op the same cycle (back-to-back) → REQ; else → IDLE.
    - Load granted → RESP, and dmem_req drops.
  - RESP: waits for dmem_rvalid.
    - On dmem_rvalid: mem_* flags are valid that cycle, load_valid is asserted the next cycle, then accept the next op → REQ, else → IDLE.
    - dmem_rvalid outside RESP is ignored.
- stall = (REQ && !(dmem_gnt && dmem_we)) || (RESP && !dmem_rvalid).
- mem_* flags: hold their value until the next accept.
- Timeout:
  - Counter clears on accept and increments every cycle in REQ or RESP.
  - When it reaches TIMEOUT_CYCLES-1 without completion: pulse bus_err, latch fault_addr, → IDLE, drop dmem_req, deassert stall.
  - Completion in the same cycle as the timeout wins; no bus_err.
- Reset mid-access forces IDLE the next edge. Any response arriving later is ignored.
- Grant and response on the same cycle for a load is not supported; the bus returns rvalid no earlier than the cycle after gnt.

Decomposition:
- Shared package lsu_pkg holds:
  - mem_size_e (BYTE/HALF/WORD)
  - lsu_state_e (IDLE/REQ/RESP)
  - function rot_amt(off) and function byte_en(size, off), shared with the datapath's bench.
- One natural sub-module: lsu_align_chk, combinational. Maps size, addr to be, rotate, and misaligned.

Test Plan:
- Store byte, addr 0x1003, gnt same cycle as req → ex_rotate_amount=01, dmem_addr=0x1000, dmem_be=1000, dmem_we=1, stall=0, one-cycle access.
- Load half signed, addr 0x2002, gnt after 2 cycles, rvalid 3 cycles later → stall high for 5 cycles, mem_rotate_amount=10, mem_half_op=1, load_valid pulses the cycle after rvalid.
- Back-to-back: store word 0x10 then store word 0x14, both immediately granted → dmem_req stays high, addresses change on consecutive cycles, no idle cycle.
- Misaligned word load at 0x3001 → no dmem_req, misaligned pulse, fault_addr=0x3001, stall=0.
- TIMEOUT_CYCLES=4, load with no gnt → bus_err after 4 cycles in REQ, dmem_req=0, stall released; late rvalid ignored.
- rst asserted in RESP → IDLE next edge, all outputs 0, following rvalid produces no load_valid.
